// File: rtl/project_selector.sv
// Project activation controller: Wishbone register window plus a
// break-before-make sequencer for the per-project output enables.

// Register window: address decode, registered single-cycle ack,
// read mux and write strobes presented during the ack cycle.
module project_selector_regs #(
   parameter logic [31:0] BASE_ADDR   = 32'h3000_0100,
   parameter int          GUARD_RESET = 4
) (
   input  logic        clk_sys,
   input  logic        rst_b,
   input  logic        stb,
   input  logic        cyc,
   input  logic        we,
   input  logic [3:0]  sel,
   input  logic [31:0] wdata,
   input  logic [31:0] adr,
   output logic        ack,
   output logic [31:0] rdata,
   input  logic [7:0]  req_idx,
   input  logic [7:0]  cur_idx,
   input  logic        busy,
   input  logic        err,
   input  logic        override,
   output logic        wr_ctrl,
   output logic        wr_clr,
   output logic [7:0]  wr_val,
   output logic [7:0]  guard
);
   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_GUARD  = 2'd2;
   localparam logic [1:0] OFF_CLR    = 2'd3;

   logic        addr_hit;
   logic        bus_req;
   logic        wr_pend;
   logic        wr_en;
   logic [1:0]  wr_off;
   logic [31:0] rd_mux;
   logic        unused_bits;

   // Only byte 0 carries register content; the rest of the bus is ignored.
   assign unused_bits = ^{sel[3:1], wdata[31:8], adr[1:0]};

   assign addr_hit = (adr[31:4] == BASE_ADDR[31:4]);
   // The ~ack term forces an idle cycle after every ack.
   assign bus_req  = stb & cyc & addr_hit & ~ack;
   assign wr_en    = ack & wr_pend;
   assign wr_ctrl  = wr_en & (wr_off == OFF_CTRL);
   assign wr_clr   = wr_en & (wr_off == OFF_CLR);

   // Read mux, sampled at the request edge.
   always_comb begin
      rd_mux = '0;
      case (adr[3:2])
         OFF_CTRL:   rd_mux = {24'd0, req_idx};
         OFF_STATUS: rd_mux = {21'd0, override, err, busy, cur_idx};
         OFF_GUARD:  rd_mux = {24'd0, guard};
         default:    rd_mux = '0;
      endcase
   end

   // Registered ack/read data; write intent is latched for the ack cycle.
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         ack     <= 1'b0;
         rdata   <= '0;
         wr_pend <= 1'b0;
         wr_off  <= OFF_CTRL;
         wr_val  <= '0;
      end else begin
         ack   <= bus_req;
         rdata <= (bus_req && !we) ? rd_mux : '0;
         if (bus_req) begin
            wr_pend <= we & sel[0];
            wr_off  <= adr[3:2];
            wr_val  <= wdata[7:0];
         end
      end
   end

   // Guard length register; zero would mean no break, so it becomes one.
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         guard <= 8'(GUARD_RESET);
      end else if (wr_en && (wr_off == OFF_GUARD)) begin
         guard <= (wr_val == 8'd0) ? 8'd1 : wr_val;
      end
   end
endmodule

// state | meaning
// IDLE  | no project enabled, CUR = 8'hFF
// GUARD | all enables low, counter running toward the new target
// ON    | project CUR enabled (one-hot)
module project_selector #(
   parameter int          NUM_PROJECTS = 3,
   parameter logic [31:0] BASE_ADDR    = 32'h3000_0100,
   parameter int          GUARD_RESET  = 4
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_n_i,
   input  logic                    wbs_stb_i,
   input  logic                    wbs_cyc_i,
   input  logic                    wbs_we_i,
   input  logic [3:0]              wbs_sel_i,
   input  logic [31:0]             wbs_dat_i,
   input  logic [31:0]             wbs_adr_i,
   output logic                    wbs_ack_o,
   output logic [31:0]             wbs_dat_o,
   input  logic                    la_override_i,
   input  logic [NUM_PROJECTS-1:0] la_active_i,
   output logic [NUM_PROJECTS-1:0] active_o,
   output logic                    busy_o
);
   localparam logic [7:0] NUM_P8   = 8'(NUM_PROJECTS);
   localparam logic [7:0] IDX_NONE = 8'hFF;

   typedef enum logic [1:0] {ST_IDLE, ST_GUARD, ST_ON} state_t;

   state_t     state;
   logic [7:0] cur;
   logic [7:0] target;
   logic [7:0] req;
   logic [7:0] cnt;
   logic       err;
   logic       ovr_q;

   logic       wr_ctrl;
   logic       wr_clr;
   logic [7:0] wr_val;
   logic [7:0] guard;
   logic       val_ok;
   logic       ovr_any;
   logic       ctrl_ok;
   logic       ctrl_bad;
   logic       switch_go;

   function automatic logic [NUM_PROJECTS-1:0] onehot(input logic [7:0] idx);
      logic [NUM_PROJECTS-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_PROJECTS; i++) begin
         if (idx == 8'(i)) v[i] = 1'b1;
      end
      return v;
   endfunction

   project_selector_regs #(
      .BASE_ADDR   (BASE_ADDR),
      .GUARD_RESET (GUARD_RESET)
   ) u_regs (
      .clk_sys  (wb_clk_i),
      .rst_b    (wb_rst_n_i),
      .stb      (wbs_stb_i),
      .cyc      (wbs_cyc_i),
      .we       (wbs_we_i),
      .sel      (wbs_sel_i),
      .wdata    (wbs_dat_i),
      .adr      (wbs_adr_i),
      .ack      (wbs_ack_o),
      .rdata    (wbs_dat_o),
      .req_idx  (req),
      .cur_idx  (cur),
      .busy     (busy_o),
      .err      (err),
      .override (la_override_i),
      .wr_ctrl  (wr_ctrl),
      .wr_clr   (wr_clr),
      .wr_val   (wr_val),
      .guard    (guard)
   );

   // A request is refused while overridden (including the release cycle,
   // which starts its own guard) or while a switch is still in flight.
   assign val_ok    = (wr_val == IDX_NONE) || (wr_val < NUM_P8);
   assign ovr_any   = la_override_i | ovr_q;
   assign ctrl_ok   = wr_ctrl & ~ovr_any & (state != ST_GUARD) & val_ok;
   assign ctrl_bad  = wr_ctrl & ~ctrl_ok;
   assign switch_go = ctrl_ok & (wr_val != cur);

   // Sequencer: enables always pass through a full guard of zeros.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state    <= ST_IDLE;
         cur      <= IDX_NONE;
         target   <= IDX_NONE;
         req      <= IDX_NONE;
         cnt      <= '0;
         err      <= 1'b0;
         ovr_q    <= 1'b0;
         active_o <= '0;
         busy_o   <= 1'b0;
      end else begin
         ovr_q <= la_override_i;

         if (wr_clr) begin
            err <= 1'b0;
         end else if (ctrl_bad) begin
            err <= 1'b1;
         end

         if (ctrl_ok) begin
            req <= wr_val;
         end

         if (la_override_i) begin
            active_o <= la_active_i;
         end else if (ovr_q) begin
            state    <= ST_GUARD;
            target   <= cur;
            cnt      <= guard;
            active_o <= '0;
            busy_o   <= 1'b1;
         end else begin
            case (state)
               ST_IDLE, ST_ON: begin
                  if (switch_go) begin
                     state    <= ST_GUARD;
                     target   <= wr_val;
                     cnt      <= guard;
                     active_o <= '0;
                     busy_o   <= 1'b1;
                  end
               end
               ST_GUARD: begin
                  if (cnt == 8'd1) begin
                     cur    <= target;
                     busy_o <= 1'b0;
                     if (target == IDX_NONE) begin
                        state    <= ST_IDLE;
                        active_o <= '0;
                     end else begin
                        state    <= ST_ON;
                        active_o <= onehot(target);
                     end
                  end else begin
                     cnt <= cnt - 8'd1;
                  end
               end
               default: begin
                  state    <= ST_IDLE;
                  active_o <= '0;
                  busy_o   <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_project_selector.sv
// Bench for project_selector: directed scenarios plus random bus/override
// traffic, every cycle compared against a timestamp-based reference model.
module tb_project_selector;
   localparam int          N    = 3;
   localparam logic [31:0] BASE = 32'h3000_0100;
   localparam int          GR   = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          stb, cyc, we;
   logic [3:0]    sel;
   logic [31:0]   dat_i, adr;
   logic          ack;
   logic [31:0]   dat_o;
   logic          la_ovr;
   logic [N-1:0]  la_act;
   logic [N-1:0]  active;
   logic          busy;

   project_selector #(.NUM_PROJECTS(N), .BASE_ADDR(BASE), .GUARD_RESET(GR)) dut (
      .wb_clk_i      (clk),
      .wb_rst_n_i    (rst_n),
      .wbs_stb_i     (stb),
      .wbs_cyc_i     (cyc),
      .wbs_we_i      (we),
      .wbs_sel_i     (sel),
      .wbs_dat_i     (dat_i),
      .wbs_adr_i     (adr),
      .wbs_ack_o     (ack),
      .wbs_dat_o     (dat_o),
      .la_override_i (la_ovr),
      .la_active_i   (la_act),
      .active_o      (active),
      .busy_o        (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model. A switch is a time window: enables are low for
   // cycles t < sw_end, and CUR takes the target when cycle sw_end begins.
   int          t = 0;
   int          sw_end = 0;
   logic [7:0]  m_cur, m_tgt, m_req, m_guard;
   logic        m_err, m_ovr_q, m_ack, m_busy;
   logic [31:0] m_dat;
   logic [N-1:0] m_act;
   logic        p_we, p_sel;
   logic [1:0]  p_off;
   logic [7:0]  p_v;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, want, t);
   endtask

   function automatic logic [N-1:0] ref_onehot(input logic [7:0] idx);
      return (idx < N) ? N'(1 << idx) : '0;
   endfunction

   task automatic model_reset();
      m_cur = 8'hFF; m_tgt = 8'hFF; m_req = 8'hFF; m_guard = 8'(GR);
      m_err = 0; m_ovr_q = 0; m_ack = 0; m_busy = 0; m_dat = 0; m_act = '0;
      sw_end = 0; p_we = 0; p_sel = 0; p_off = 0; p_v = 0;
   endtask

   // Advance the model across one rising edge using the inputs now applied.
   task automatic model_step();
      bit          busy_now, ovr_any, hit, wr_en;
      int          sw_end_n;
      logic [7:0]  cur_n, tgt_n;
      logic        ack_n;
      logic [31:0] dat_n;
      busy_now = (t < sw_end);
      ovr_any  = la_ovr || m_ovr_q;
      wr_en    = m_ack && p_we && p_sel;
      sw_end_n = sw_end; cur_n = m_cur; tgt_n = m_tgt;

      hit   = stb && cyc && (adr[31:4] == BASE[31:4]) && !m_ack;
      ack_n = hit;
      dat_n = 0;
      if (hit && !we) begin
         case (adr[3:2])
            2'd0: dat_n = {24'd0, m_req};
            2'd1: dat_n = {21'd0, la_ovr, m_err, busy_now, m_cur};
            2'd2: dat_n = {24'd0, m_guard};
            default: dat_n = 0;
         endcase
      end

      if (la_ovr) begin
         if (busy_now) sw_end_n = sw_end + 1;
      end else if (m_ovr_q) begin
         sw_end_n = t + 1 + int'(m_guard);
         tgt_n    = m_cur;
      end else if (busy_now && (t + 1 == sw_end)) begin
         cur_n = m_tgt;
      end

      if (wr_en) begin
         case (p_off)
            2'd0: begin
               if (!ovr_any && !busy_now && (p_v == 8'hFF || p_v < N)) begin
                  m_req = p_v;
                  if (p_v != m_cur) begin
                     sw_end_n = t + 1 + int'(m_guard);
                     tgt_n    = p_v;
                  end
               end else begin
                  m_err = 1;
               end
            end
            2'd2: m_guard = (p_v == 0) ? 8'd1 : p_v;
            2'd3: m_err = 0;
            default: ;
         endcase
      end

      m_busy = (t + 1 < sw_end_n);
      if (la_ovr)      m_act = la_act;
      else if (m_busy) m_act = '0;
      else             m_act = ref_onehot(cur_n);

      m_cur = cur_n; m_tgt = tgt_n; sw_end = sw_end_n;
      m_ovr_q = la_ovr; m_ack = ack_n; m_dat = dat_n;
      if (hit) begin
         p_we = we; p_sel = sel[0]; p_off = adr[3:2]; p_v = dat_i[7:0];
      end
      t++;
   endtask

   task automatic cycle_step();
      model_step();
      @(negedge clk);
      check_val("active", 32'(active), 32'(m_act));
      check_val("busy",   32'(busy),   32'(m_busy));
      check_val("ack",    32'(ack),    32'(m_ack));
      check_val("dat",    dat_o,       m_dat);
   endtask

   task automatic bus_idle();
      stb = 0; cyc = 0; we = 0; sel = 4'h0; adr = 0; dat_i = 0;
   endtask

   task automatic wb_write(input logic [7:0] off, input logic [7:0] v);
      stb = 1; cyc = 1; we = 1; sel = 4'hF; adr = BASE + 32'(off); dat_i = {24'd0, v};
      cycle_step();
      bus_idle();
      cycle_step();
   endtask

   task automatic wb_read(input logic [7:0] off, output logic [31:0] d, output logic a);
      stb = 1; cyc = 1; we = 0; sel = 4'hF; adr = BASE + 32'(off); dat_i = 0;
      cycle_step();
      d = dat_o; a = ack;
      bus_idle();
      cycle_step();
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 64) begin
         cycle_step();
         n++;
      end
   endtask

   task automatic drive_random();
      int r;
      stb = ($urandom_range(0, 99) < 40);
      cyc = stb ? ($urandom_range(0, 9) != 0) : 1'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      sel = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 19);
      if (r == 0)      adr = $urandom;
      else if (r == 1) adr = BASE + 32'h10;
      else             adr = BASE | 32'($urandom_range(0, 15));
      dat_i = $urandom;
      case ($urandom_range(0, 5))
         0: dat_i[7:0] = 8'h00;
         1: dat_i[7:0] = 8'h01;
         2: dat_i[7:0] = 8'h02;
         3: dat_i[7:0] = 8'hFF;
         default: ;
      endcase
      if (adr[3:2] == 2'd2) dat_i[7:0] = 8'($urandom_range(0, 6));
      if (la_ovr) begin
         if ($urandom_range(0, 99) < 10) la_ovr = 0;
      end else begin
         if ($urandom_range(0, 99) < 2) la_ovr = 1;
      end
      la_act = N'($urandom_range(0, 7));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic        a;
      int          n;

      rst_n = 0; la_ovr = 0; la_act = '0;
      bus_idle();
      model_reset();
      repeat (3) @(negedge clk);
      check_val("rst_active", 32'(active), 32'h0);
      check_val("rst_busy",   32'(busy),   32'h0);
      check_val("rst_ack",    32'(ack),    32'h0);
      check_val("rst_dat",    dat_o,       32'h0);
      rst_n = 1;

      // Reset status
      wb_read(8'h4, d, a);
      check_val("status_reset", d, 32'h0000_00FF);

      // First activation
      wb_write(8'h0, 8'h01);
      count_busy(n);
      check_val("guard_len_1", 32'(n), 32'd4);
      check_val("on_1", 32'(active), 32'b010);
      wb_read(8'h4, d, a);
      check_val("status_cur1", d, 32'h0000_0001);

      // Switch 1 -> 2, then an out-of-range request
      wb_write(8'h0, 8'h02);
      count_busy(n);
      check_val("guard_len_2", 32'(n), 32'd4);
      check_val("on_2", 32'(active), 32'b100);
      wb_write(8'h0, 8'h05);
      check_val("bad_idx_keep", 32'(active), 32'b100);
      wb_read(8'h4, d, a);
      check_val("status_err", d, 32'h0000_0202);
      wb_write(8'hC, 8'h00);
      wb_read(8'h4, d, a);
      check_val("status_clr", d, 32'h0000_0002);

      // Request during a guard interval is refused
      wb_write(8'h0, 8'h01);
      wb_write(8'h0, 8'h00);
      count_busy(n);
      check_val("on_after_busy_req", 32'(active), 32'b010);
      wb_read(8'h4, d, a);
      check_val("status_busy_err", d, 32'h0000_0201);
      wb_read(8'h0, d, a);
      check_val("ctrl_readback", d, 32'h0000_0001);
      wb_write(8'hC, 8'h00);

      // Logic-analyzer override and its release guard
      la_act = 3'b011; la_ovr = 1;
      cycle_step();
      check_val("ovr_active", 32'(active), 32'b011);
      cycle_step();
      cycle_step();
      la_ovr = 0;
      cycle_step();
      check_val("ovr_release_low", 32'(active), 32'b000);
      count_busy(n);
      check_val("ovr_guard_len", 32'(n), 32'd4);
      check_val("ovr_resume", 32'(active), 32'b010);

      // GUARD=0 is stored as 1: single low cycle
      wb_write(8'h8, 8'h00);
      wb_read(8'h8, d, a);
      check_val("guard_zero", d, 32'h0000_0001);
      wb_write(8'h0, 8'h00);
      count_busy(n);
      check_val("guard_len_min", 32'(n), 32'd1);
      check_val("on_0", 32'(active), 32'b001);
      wb_write(8'h8, 8'd4);

      // Reset in the middle of a guard interval
      wb_write(8'h0, 8'h02);
      cycle_step();
      #2 rst_n = 0;
      #1;
      check_val("midrst_active", 32'(active), 32'h0);
      check_val("midrst_busy",   32'(busy),   32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      wb_read(8'h4, d, a);
      check_val("status_after_rst", d, 32'h0000_00FF);
      wb_read(8'h10, d, a);
      check_val("miss_ack", 32'(a), 32'h0);
      check_val("miss_dat", d, 32'h0);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         drive_random();
         cycle_step();
      end
      bus_idle();
      la_ovr = 0;
      repeat (20) cycle_step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
